lsq_stdrain_arb: RTL and testbench
==================================

# lsq_stdrain_arb

Store-drain arbiter between the two per-thread retired-store queues and the two L1 write ports. Each cycle it picks up to two stores from the thread queue heads, which hold bundles of up to 3 stores, and keeps program order within a thread. It never places two stores with overlapping bank masks in the same cycle. It tracks partially drained bundles and pops a queue head once every store in that bundle has been written. It sits between the store-queue retire muxing and the data-cache write pipeline, which may stall.

## Interface
- BANKS, 32, bank-mask width per store
- SLOTS, 3, stores per bundle; fixed by the storq output muxing
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- t0_valid  in  1  thread-0 queue head holds a bundle
- t0_mask  in  SLOTS  slots holding a store
- t0_banks  in  SLOTS*BANKS  bank mask per slot; slot s is bits [s*BANKS +: BANKS]
- t0_pop  out  1  bundle fully written; queue advances
- t1_valid, t1_mask, t1_banks, t1_pop  same as above, for thread 1
- wr_stall  in  1  cache rejects this cycle's writes
- wr_en  out  2  write-port enables; port 0 and port 1
- wr_thr  out  2  thread per port
- wr_slot  out  4  slot index per port, 2 bits each
- empty  out  1  no valid head and no partial bundle

## Operation
- State:
  - done0, done1 (SLOTS bits each): slots already written.
  - rr (1 bit): priority thread.
- pend_t = tN_mask & ~doneN & {SLOTS{tN_valid}}.
- Primary thread P: rr if pend_rr≠0, else the other thread if its pend≠0, else none.
- Port 0: lowest set bit of pend_P.
- Port 1, first choice: next-lowest set bit of pend_P, only if its banks are disjoint from port 0's banks.
  - A later slot of P is never taken while an earlier slot of P is unwritten. This is the in-order rule.
- Port 1, otherwise: lowest set bit of the other thread's pend, if its banks are disjoint from port 0's banks.
  - Cross-thread order is free.
  - Only that thread's lowest pending slot may be used.
- Port 1 is never used when port 0 is idle.
- A slot whose bank mask is all zero conflicts with nothing.
- On a clock edge with wr_stall=0:
  - Set the done bits of the granted slots.
  - tN_pop=1 when (doneN | this cycle's grants to N) covers tN_mask. At that edge, doneN clears to 0.
  - A valid bundle with mask=0 pops immediately with no grant.
  - When P pops, rr ← ~P. Otherwise rr holds.
- wr_stall=1:
  - wr_en still shows the proposed grant; the cache ignores it.
  - pop is forced to 0, and done and rr hold.
  - The same grant re-presents next cycle if the inputs are unchanged.
- Input protocol: tN_mask and tN_banks are stable while tN_valid=1 and until pop. Dropping valid without a pop is an error. The bench asserts on it; the RTL behaviour is undefined.
- empty = ~t0_valid & ~t1_valid & (done0==0) & (done1==0).
- Reset values:
  - done0, done1 = 0; rr = 0.
  - All outputs low except empty=1, because the inputs are invalid during reset.
- Async reset assertion in the middle of a bundle discards its done bits. After reset, the bundle re-drains from slot 0. Cache writes are idempotent, so this is allowed.

## Timing
- Grants and pops are combinational from inputs and state, with zero latency.
- State updates at posedge clk when wr_stall=0.
- Maximum throughput is 2 stores per cycle.
- A 3-store bundle with no conflicts drains in 2 cycles. A fully conflicting 3-store bundle drains in 3 cycles.
- Pop is a single-cycle pulse. The queue presents its next bundle in the following cycle; a new bundle is never granted in the same cycle as a pop.
- Critical path: pend → priority find → 32-bit bank AND-reduce → port-1 select. No pipelining is required at this size.

## Structure
- lsq_pkg holds SLOTS, BANKS, a typedef for the slot index (2 bits), and a typedef for the bank mask. The storq mux and the retire logic share these.
- One sub-module, lsq_drain_pick. It is purely combinational and instantiated per thread. Inputs: pend and banks. Outputs: first slot, second slot, their valid bits, and the bank masks of both.
- The top level holds done/rr state, port-1 conflict resolution, pop and empty logic.

## Test plan
- Thread 0 only, mask=111, banks s0=0x1, s1=0x2, s2=0x4, no stall:
  - Cycle 0: ports get (t0,s0) and (t0,s1).
  - Cycle 1: port 0 gets (t0,s2) and t0_pop=1.
  - rr becomes 1.
- Thread 0 only, mask=011, banks s0=s1=0x10:
  - Cycle 0: only port 0 is enabled, (t0,s0).
  - Cycle 1: (t0,s1) is granted and t0_pop=1.
- Both valid, rr=0; t0 mask=011 with s0=s1=0x1; t1 mask=001 with s0=0x8000:
  - Cycle 0: port 0 (t0,s0), port 1 (t1,s0), t1_pop=1.
  - Cycle 1: (t0,s1) is granted and t0_pop=1.
  - rr becomes 1.
- Hold wr_stall=1 for 3 cycles with the first scenario's stimulus:
  - The same cycle-0 grant is shown for all 3 cycles, with no pop and done=0.
  - After release, the first scenario's sequence follows exactly.
- Assert rst low after cycle 0 of the first scenario, then release:
  - done=0 and empty reflects the inputs.
  - The bundle re-drains as s0+s1, then s2.
- Valid t1 with mask=000, and t0 invalid: t1_pop=1 in the same cycle, wr_en=00.

Source files
------------

// File: rtl/lsq_pkg.sv
// Store-queue geometry shared by the storq output mux, the retire logic and the drain arbiter.
package lsq_pkg;
  localparam int BANKS = 32;
  localparam int SLOTS = 3;

  typedef logic [1:0]       slot_idx_t;
  typedef logic [BANKS-1:0] bank_mask_t;
  typedef logic [SLOTS-1:0] slot_vec_t;
endpackage

// File: rtl/lsq_stdrain_arb_if.sv
// Store-drain bus: two retired-store queue heads in, two L1 write ports and queue pops out.
interface lsq_stdrain_arb_if;
  import lsq_pkg::*;

  logic                   t0_valid;
  slot_vec_t              t0_mask;
  logic [SLOTS*BANKS-1:0] t0_banks;
  logic                   t0_pop;
  logic                   t1_valid;
  slot_vec_t              t1_mask;
  logic [SLOTS*BANKS-1:0] t1_banks;
  logic                   t1_pop;
  logic                   wr_stall;
  logic [1:0]             wr_en;
  logic [1:0]             wr_thr;
  logic [3:0]             wr_slot;
  logic                   empty;

  modport master (
    output t0_valid, t0_mask, t0_banks, t1_valid, t1_mask, t1_banks, wr_stall,
    input  t0_pop, t1_pop, wr_en, wr_thr, wr_slot, empty
  );

  modport slave (
    input  t0_valid, t0_mask, t0_banks, t1_valid, t1_mask, t1_banks, wr_stall,
    output t0_pop, t1_pop, wr_en, wr_thr, wr_slot, empty
  );
endinterface

// File: rtl/lsq_drain_pick.sv
// Finds the two lowest pending slots of one thread's bundle and forwards their bank masks.
module lsq_drain_pick
  import lsq_pkg::*;
(
  input  slot_vec_t              pend_i,
  input  logic [SLOTS*BANKS-1:0] banks_i,
  output logic                   first_vld_o,
  output slot_idx_t              first_slot_o,
  output bank_mask_t             first_banks_o,
  output logic                   second_vld_o,
  output slot_idx_t              second_slot_o,
  output bank_mask_t             second_banks_o
);
  logic      got_first, got_second;
  slot_idx_t slot_a, slot_b;
  bank_mask_t banks_a, banks_b;

  always_comb begin
    got_first  = 1'b0;
    got_second = 1'b0;
    slot_a     = '0;
    slot_b     = '0;
    banks_a    = '0;
    banks_b    = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (pend_i[s]) begin
        if (!got_first) begin
          got_first = 1'b1;
          slot_a    = slot_idx_t'(s);
          banks_a   = banks_i[s*BANKS +: BANKS];
        end else if (!got_second) begin
          got_second = 1'b1;
          slot_b     = slot_idx_t'(s);
          banks_b    = banks_i[s*BANKS +: BANKS];
        end
      end
    end
  end

  assign first_vld_o    = got_first;
  assign first_slot_o   = slot_a;
  assign first_banks_o  = banks_a;
  assign second_vld_o   = got_second;
  assign second_slot_o  = slot_b;
  assign second_banks_o = banks_b;
endmodule

// File: rtl/lsq_stdrain_arb.sv
// Drains retired-store bundles from two thread queues into two L1 write ports, in program
// order per thread and never placing two bank-overlapping stores in the same cycle.
module lsq_stdrain_arb
  import lsq_pkg::*;
(
  input logic              clk_i,
  input logic              rst_ni,
  lsq_stdrain_arb_if.slave bus
);
  logic                   valid   [2];
  slot_vec_t              mask    [2];
  logic [SLOTS*BANKS-1:0] banks   [2];
  slot_vec_t              pend    [2];
  slot_vec_t              done_q  [2];
  slot_vec_t              done_d  [2];
  slot_vec_t              grant   [2];
  slot_vec_t              covered [2];
  logic                   pop     [2];
  logic                   f_vld   [2];
  logic                   s_vld   [2];
  slot_idx_t              f_slot  [2];
  slot_idx_t              s_slot  [2];
  bank_mask_t             f_banks [2];
  bank_mask_t             s_banks [2];
  logic                   rr_q, rr_d;
  logic                   prim_vld, prim, oth;
  logic [1:0]             wr_en, wr_thr;
  logic [3:0]             wr_slot;

  assign valid[0] = bus.t0_valid;
  assign valid[1] = bus.t1_valid;
  assign mask[0]  = bus.t0_mask;
  assign mask[1]  = bus.t1_mask;
  assign banks[0] = bus.t0_banks;
  assign banks[1] = bus.t1_banks;

  for (genvar t = 0; t < 2; t++) begin : g_thr
    assign pend[t] = mask[t] & ~done_q[t] & {SLOTS{valid[t]}};

    lsq_drain_pick u_pick (
      .pend_i        (pend[t]),
      .banks_i       (banks[t]),
      .first_vld_o   (f_vld[t]),
      .first_slot_o  (f_slot[t]),
      .first_banks_o (f_banks[t]),
      .second_vld_o  (s_vld[t]),
      .second_slot_o (s_slot[t]),
      .second_banks_o(s_banks[t])
    );
  end

  // Port 1 prefers the primary thread's next slot; only when that conflicts with port 0
  // may the other thread's oldest pending store slip in.
  always_comb begin
    prim_vld = f_vld[rr_q] | f_vld[~rr_q];
    prim     = f_vld[rr_q] ? rr_q : ~rr_q;
    oth      = ~prim;
    wr_en    = '0;
    wr_thr   = '0;
    wr_slot  = '0;
    if (prim_vld) begin
      wr_en[0]     = 1'b1;
      wr_thr[0]    = prim;
      wr_slot[1:0] = f_slot[prim];
      if (s_vld[prim] && ((s_banks[prim] & f_banks[prim]) == '0)) begin
        wr_en[1]     = 1'b1;
        wr_thr[1]    = prim;
        wr_slot[3:2] = s_slot[prim];
      end else if (f_vld[oth] && ((f_banks[oth] & f_banks[prim]) == '0)) begin
        wr_en[1]     = 1'b1;
        wr_thr[1]    = oth;
        wr_slot[3:2] = f_slot[oth];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      grant[t] = '0;
      for (int s = 0; s < SLOTS; s++) begin
        grant[t][s] = (wr_en[0] && (wr_thr[0] == t[0]) && (wr_slot[1:0] == s[1:0])) ||
                      (wr_en[1] && (wr_thr[1] == t[0]) && (wr_slot[3:2] == s[1:0]));
      end
    end
  end

  // A stalled cycle still shows its grant but commits nothing, so it re-presents unchanged.
  always_comb begin
    rr_d = rr_q;
    for (int t = 0; t < 2; t++) begin
      covered[t] = done_q[t] | grant[t];
      pop[t]     = valid[t] && ((mask[t] & ~covered[t]) == '0) && !bus.wr_stall;
      done_d[t]  = done_q[t];
      if (!bus.wr_stall) begin
        done_d[t] = pop[t] ? '0 : covered[t];
      end
    end
    if (prim_vld && pop[prim]) begin
      rr_d = ~prim;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q[0] <= '0;
      done_q[1] <= '0;
      rr_q      <= 1'b0;
    end else begin
      done_q[0] <= done_d[0];
      done_q[1] <= done_d[1];
      rr_q      <= rr_d;
    end
  end

  assign bus.wr_en   = wr_en;
  assign bus.wr_thr  = wr_thr;
  assign bus.wr_slot = wr_slot;
  assign bus.t0_pop  = pop[0];
  assign bus.t1_pop  = pop[1];
  assign bus.empty   = ~valid[0] & ~valid[1] & (done_q[0] == '0) & (done_q[1] == '0);
endmodule

// File: tb/tb_lsq_stdrain_arb.sv
// Self-checking bench for the store-drain arbiter: directed scenarios plus a randomized
// run against a slot-list reference model of the drain rules.
module tb_lsq_stdrain_arb;
  import lsq_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;

  lsq_stdrain_arb_if bus ();

  lsq_stdrain_arb dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: bundle presented per thread, slots already written, priority thread.
  logic        tv     [2];
  logic [2:0]  tmask  [2];
  logic [31:0] tbanks [2][3];
  logic        tstall;
  logic [2:0]  mdone  [2];
  int          mrr;
  int          mprim;
  logic [2:0]  mgr    [2];
  logic [1:0]  mpop;

  // Packed view of the write ports with idle ports zeroed: {en1,en0,thr1,slot1,thr0,slot0}.
  function automatic logic [7:0] mk(bit e0, int ta, int sa, bit e1, int tb, int sb);
    logic [7:0] r;
    r    = '0;
    r[6] = e0;
    r[7] = e1;
    if (e0) begin r[2] = ta[0]; r[1:0] = sa[1:0]; end
    if (e1) begin r[5] = tb[0]; r[4:3] = sb[1:0]; end
    return r;
  endfunction

  function automatic logic [7:0] view();
    logic [7:0] r;
    r    = '0;
    r[6] = bus.wr_en[0];
    r[7] = bus.wr_en[1];
    if (bus.wr_en[0]) begin r[2] = bus.wr_thr[0]; r[1:0] = bus.wr_slot[1:0]; end
    if (bus.wr_en[1]) begin r[5] = bus.wr_thr[1]; r[4:3] = bus.wr_slot[3:2]; end
    return r;
  endfunction

  task automatic drive_thr(int t, logic v, logic [2:0] m, logic [31:0] b0, logic [31:0] b1,
                           logic [31:0] b2);
    if (t == 0) begin
      bus.t0_valid = v; bus.t0_mask = m; bus.t0_banks = {b2, b1, b0};
    end else begin
      bus.t1_valid = v; bus.t1_mask = m; bus.t1_banks = {b2, b1, b0};
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
    drive_thr(1, 1'b0, 3'b000, 0, 0, 0);
    bus.wr_stall = 1'b0;
    rst_ni       = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Protocol monitor: a head may only be withdrawn after it has popped.
  logic held [2] = '{1'b0, 1'b0};
  always @(posedge clk) begin
    if (!rst_ni) begin
      held[0] <= 1'b0;
      held[1] <= 1'b0;
    end else begin
      if (held[0]) begin
        checks++;
        if (!bus.t0_valid) begin errors++; $display("[TB] FAIL protocol_t0: valid dropped without pop"); end
      end
      if (held[1]) begin
        checks++;
        if (!bus.t1_valid) begin errors++; $display("[TB] FAIL protocol_t1: valid dropped without pop"); end
      end
      held[0] <= bus.t0_valid && !bus.t0_pop;
      held[1] <= bus.t1_valid && !bus.t1_pop;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.wr_en !== 2'b00) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 00", bus.wr_en); end
    checks++;
    if ({bus.wr_thr, bus.wr_slot} !== 6'b0) begin errors++; $display("[TB] FAIL reset_thr_slot: got %b expected 0", {bus.wr_thr, bus.wr_slot}); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pop: got %b expected 00", {bus.t1_pop, bus.t0_pop}); end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_no_conflict();
    do_reset();
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b111, 32'h1, 32'h2, 32'h4);
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL nc_c0_grant: got %h expected %h", view(), mk(1, 0, 0, 1, 0, 1)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b00) begin errors++; $display("[TB] FAIL nc_c0_pop: got %b expected 00", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    #1;
    checks++;
    if (view() !== mk(1, 0, 2, 0, 0, 0)) begin errors++; $display("[TB] FAIL nc_c1_grant: got %h expected %h", view(), mk(1, 0, 2, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b01) begin errors++; $display("[TB] FAIL nc_c1_pop: got %b expected 01", {bus.t1_pop, bus.t0_pop}); end
    // rr is now 1, so thread 1 takes port 0 when both offer a store.
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b001, 32'h1, 0, 0);
    drive_thr(1, 1'b1, 3'b001, 32'h2, 0, 0);
    #1;
    checks++;
    if (view() !== mk(1, 1, 0, 1, 0, 0)) begin errors++; $display("[TB] FAIL nc_rr_grant: got %h expected %h", view(), mk(1, 1, 0, 1, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b11) begin errors++; $display("[TB] FAIL nc_rr_pop: got %b expected 11", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
    drive_thr(1, 1'b0, 3'b000, 0, 0, 0);
    #1;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL nc_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_bank_conflict();
    do_reset();
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b011, 32'h10, 32'h10, 32'h0);
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 0, 0, 0)) begin errors++; $display("[TB] FAIL bc_c0_grant: got %h expected %h", view(), mk(1, 0, 0, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop, bus.empty} !== 3'b000) begin errors++; $display("[TB] FAIL bc_c0_pop_empty: got %b expected 000", {bus.t1_pop, bus.t0_pop, bus.empty}); end
    @(negedge clk);
    #1;
    checks++;
    if (view() !== mk(1, 0, 1, 0, 0, 0)) begin errors++; $display("[TB] FAIL bc_c1_grant: got %h expected %h", view(), mk(1, 0, 1, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b01) begin errors++; $display("[TB] FAIL bc_c1_pop: got %b expected 01", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
  endtask

  task automatic test_cross_thread();
    do_reset();
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b011, 32'h1, 32'h1, 32'h0);
    drive_thr(1, 1'b1, 3'b001, 32'h8000, 32'h0, 32'h0);
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 1, 1, 0)) begin errors++; $display("[TB] FAIL ct_c0_grant: got %h expected %h", view(), mk(1, 0, 0, 1, 1, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b10) begin errors++; $display("[TB] FAIL ct_c0_pop: got %b expected 10", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(1, 1'b0, 3'b000, 0, 0, 0);
    #1;
    checks++;
    if (view() !== mk(1, 0, 1, 0, 0, 0)) begin errors++; $display("[TB] FAIL ct_c1_grant: got %h expected %h", view(), mk(1, 0, 1, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b01) begin errors++; $display("[TB] FAIL ct_c1_pop: got %b expected 01", {bus.t1_pop, bus.t0_pop}); end
    // With rr=1 and conflicting single stores, thread 1 goes alone first.
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b001, 32'h1, 0, 0);
    drive_thr(1, 1'b1, 3'b001, 32'h1, 0, 0);
    #1;
    checks++;
    if (view() !== mk(1, 1, 0, 0, 0, 0)) begin errors++; $display("[TB] FAIL ct_rr_grant: got %h expected %h", view(), mk(1, 1, 0, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b10) begin errors++; $display("[TB] FAIL ct_rr_pop: got %b expected 10", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(1, 1'b0, 3'b000, 0, 0, 0);
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 0, 0, 0)) begin errors++; $display("[TB] FAIL ct_tail_grant: got %h expected %h", view(), mk(1, 0, 0, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b01) begin errors++; $display("[TB] FAIL ct_tail_pop: got %b expected 01", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b111, 32'h1, 32'h2, 32'h4);
    bus.wr_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (view() !== mk(1, 0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL stall_grant%0d: got %h expected %h", c, view(), mk(1, 0, 0, 1, 0, 1)); end
      checks++;
      if ({bus.t1_pop, bus.t0_pop} !== 2'b00) begin errors++; $display("[TB] FAIL stall_pop%0d: got %b expected 00", c, {bus.t1_pop, bus.t0_pop}); end
    end
    @(negedge clk);
    bus.wr_stall = 1'b0;
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL stall_rel_c0: got %h expected %h", view(), mk(1, 0, 0, 1, 0, 1)); end
    @(negedge clk);
    #1;
    checks++;
    if (view() !== mk(1, 0, 2, 0, 0, 0)) begin errors++; $display("[TB] FAIL stall_rel_c1: got %h expected %h", view(), mk(1, 0, 2, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b01) begin errors++; $display("[TB] FAIL stall_rel_pop: got %b expected 01", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge clk);
    drive_thr(0, 1'b1, 3'b111, 32'h1, 32'h2, 32'h4);
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL mr_c0_grant: got %h expected %h", view(), mk(1, 0, 0, 1, 0, 1)); end
    @(negedge clk);
    rst_ni = 1'b0;
    bus.t0_valid = 1'b0;
    #1;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL mr_empty_idle: got %b expected 1", bus.empty); end
    bus.t0_valid = 1'b1;
    #1;
    checks++;
    if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL mr_empty_valid: got %b expected 0", bus.empty); end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (view() !== mk(1, 0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL mr_redrain_c0: got %h expected %h", view(), mk(1, 0, 0, 1, 0, 1)); end
    @(negedge clk);
    #1;
    checks++;
    if (view() !== mk(1, 0, 2, 0, 0, 0)) begin errors++; $display("[TB] FAIL mr_redrain_c1: got %h expected %h", view(), mk(1, 0, 2, 0, 0, 0)); end
    checks++;
    if ({bus.t1_pop, bus.t0_pop} !== 2'b01) begin errors++; $display("[TB] FAIL mr_redrain_pop: got %b expected 01", {bus.t1_pop, bus.t0_pop}); end
    @(negedge clk);
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
  endtask

  task automatic test_empty_mask();
    do_reset();
    @(negedge clk);
    drive_thr(1, 1'b1, 3'b000, 32'h1, 32'h2, 32'h4);
    bus.wr_stall = 1'b1;
    #1;
    checks++;
    if ({bus.t1_pop, bus.t0_pop, bus.wr_en} !== 4'b0000) begin errors++; $display("[TB] FAIL em_stalled: got %b expected 0000", {bus.t1_pop, bus.t0_pop, bus.wr_en}); end
    @(negedge clk);
    bus.wr_stall = 1'b0;
    #1;
    checks++;
    if ({bus.t1_pop, bus.t0_pop, bus.wr_en} !== 4'b1000) begin errors++; $display("[TB] FAIL em_pop: got %b expected 1000", {bus.t1_pop, bus.t0_pop, bus.wr_en}); end
    @(negedge clk);
    drive_thr(1, 1'b0, 3'b000, 0, 0, 0);
    #1;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL em_empty: got %b expected 1", bus.empty); end
  endtask

  // Reference model: list each thread's unwritten slots oldest-first and apply the drain rules.
  function automatic void model_eval(output logic [7:0] ev, output logic ee);
    int pl [2][3];
    int pc [2];
    int p, o;
    for (int t = 0; t < 2; t++) begin
      pc[t]  = 0;
      mgr[t] = 3'b000;
      for (int s = 0; s < 3; s++) begin
        if (tv[t] && tmask[t][s] && !mdone[t][s]) begin pl[t][pc[t]] = s; pc[t]++; end
      end
    end
    ev = '0;
    p  = -1;
    if (pc[mrr] > 0) p = mrr;
    else if (pc[1-mrr] > 0) p = 1 - mrr;
    mprim = p;
    if (p >= 0) begin
      o = 1 - p;
      ev = mk(1, p, pl[p][0], 0, 0, 0);
      mgr[p][pl[p][0]] = 1'b1;
      if (pc[p] > 1 && (tbanks[p][pl[p][1]] & tbanks[p][pl[p][0]]) == 0) begin
        ev = mk(1, p, pl[p][0], 1, p, pl[p][1]);
        mgr[p][pl[p][1]] = 1'b1;
      end else if (pc[o] > 0 && (tbanks[o][pl[o][0]] & tbanks[p][pl[p][0]]) == 0) begin
        ev = mk(1, p, pl[p][0], 1, o, pl[o][0]);
        mgr[o][pl[o][0]] = 1'b1;
      end
    end
    for (int t = 0; t < 2; t++) begin
      mpop[t] = tv[t] && ((tmask[t] & ~(mdone[t] | mgr[t])) == 3'b000) && !tstall;
    end
    ee = !tv[0] && !tv[1] && (mdone[0] == 3'b000) && (mdone[1] == 3'b000);
  endfunction

  function automatic logic [31:0] rand_banks();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h2;
      3:       return 32'h4;
      default: return 32'h8000_0001;
    endcase
  endfunction

  task automatic test_random();
    logic [7:0] ev;
    logic       ee;
    do_reset();
    mdone[0] = 3'b000; mdone[1] = 3'b000; mrr = 0;
    mpop = 2'b00;
    tv[0] = 1'b0; tv[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int t = 0; t < 2; t++) begin
        if (!tv[t] || mpop[t]) begin
          tv[t] = ($urandom_range(0, 2) != 0);
          if (tv[t]) begin
            tmask[t] = 3'($urandom_range(0, 7));
            for (int s = 0; s < 3; s++) tbanks[t][s] = rand_banks();
          end
        end
        drive_thr(t, tv[t], tmask[t], tbanks[t][0], tbanks[t][1], tbanks[t][2]);
      end
      tstall = ($urandom_range(0, 3) == 0);
      bus.wr_stall = tstall;
      #1;
      model_eval(ev, ee);
      checks++;
      if (view() !== ev) begin errors++; $display("[TB] FAIL rnd_grant@%0d: got %h expected %h", c, view(), ev); end
      checks++;
      if ({bus.t1_pop, bus.t0_pop} !== mpop) begin errors++; $display("[TB] FAIL rnd_pop@%0d: got %b expected %b", c, {bus.t1_pop, bus.t0_pop}, mpop); end
      checks++;
      if (bus.empty !== ee) begin errors++; $display("[TB] FAIL rnd_empty@%0d: got %b expected %b", c, bus.empty, ee); end
      @(posedge clk);
      if (!tstall) begin
        for (int t = 0; t < 2; t++) mdone[t] = mpop[t] ? 3'b000 : (mdone[t] | mgr[t]);
        if (mprim >= 0 && mpop[mprim]) mrr = 1 - mprim;
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.wr_stall = 1'b0;
    drive_thr(0, 1'b0, 3'b000, 0, 0, 0);
    drive_thr(1, 1'b0, 3'b000, 0, 0, 0);
    test_reset();
    test_no_conflict();
    test_bank_conflict();
    test_cross_thread();
    test_stall();
    test_mid_reset();
    test_empty_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
